// File: rtl/sensor_ctrl_pkg.sv
// sensor_ctrl_pkg: shared state encoding, frame counter width and Gray helper for the sensor frame sequencer
package sensor_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ} frame_state_t;

    localparam int FRAME_COUNT_BITS = 16;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sensor_gray_ramp.sv
// sensor_gray_ramp: binary ramp counter presented as a Gray-coded value
module sensor_gray_ramp
    import sensor_ctrl_pkg::*;
#(
    parameter int PIXEL_BITS = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CLEAR,
    input  logic                  ENABLE,
    output logic [PIXEL_BITS-1:0] OUT
);

    logic [PIXEL_BITS-1:0] bin;

    // ramp count; CLEAR has priority so a new frame always starts from zero
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) bin <= '0;
        else if (CLEAR) bin <= '0;
        else if (ENABLE) bin <= bin + PIXEL_BITS'(1);

    assign OUT = PIXEL_BITS'(bin2gray(32'(bin)));

endmodule

// File: rtl/sensor_frame_ctrl.sv
// sensor_frame_ctrl: erase/expose/convert/read frame sequencer; define SENSOR_FRAME_COUNT_EN to add the FRAME_COUNT output
module sensor_frame_ctrl
    import sensor_ctrl_pkg::*;
#(
    parameter int ROWS            = 8,
    parameter int PIXEL_BITS      = 8,
    parameter int ERASE_CYCLES    = 5,
    parameter int ROW_READ_CYCLES = 5,
    parameter int EXP_BITS        = 10
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        START,
    input  logic                        CONTINUOUS,
    input  logic                        ABORT,
    input  logic [EXP_BITS-1:0]         EXPOSE_TIME,
    output logic                        BUSY,
    output logic                        PIXEL_ERASE,
    output logic                        PIXEL_EXPOSE,
    output logic                        ANALOG_RAMP_EN,
    output logic [PIXEL_BITS-1:0]       DIGITAL_RAMP,
    output logic [ROWS-1:0]             ROW_SELECT,
    output logic                        NEW_ROW,
`ifdef SENSOR_FRAME_COUNT_EN
    output logic [FRAME_COUNT_BITS-1:0] FRAME_COUNT,
`endif
    output logic                        FRAME_DONE
);

    localparam int MAX_AB  = ERASE_CYCLES > ROW_READ_CYCLES ? ERASE_CYCLES : ROW_READ_CYCLES;
    localparam int MAX_CD  = EXP_BITS > PIXEL_BITS ? 2**EXP_BITS : 2**PIXEL_BITS;
    localparam int CNT_MAX = MAX_AB > MAX_CD ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int ROW_W   = ROWS > 1 ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] ERASE_LAST   = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST    = CNT_W'(2**PIXEL_BITS - 1);
    localparam logic [CNT_W-1:0] ROW_CYC_LAST = CNT_W'(ROW_READ_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROWS - 1);

    frame_state_t        state;
    logic [CNT_W-1:0]    cnt;
    logic [ROW_W-1:0]    row;
    logic [EXP_BITS-1:0] exp_lat;
    logic                phase_last;
    logic                last_read;
    logic                start_frame;
    logic                ramp_clear;
    logic                ramp_en;

    // end-of-phase and frame-start decode from the registered state and counters
    always_comb begin
        phase_last  = (state == ERASE   && cnt == ERASE_LAST) ||
                      (state == EXPOSE  && cnt == CNT_W'(exp_lat) - CNT_W'(1)) ||
                      (state == CONVERT && cnt == CONV_LAST) ||
                      (state == READ    && cnt == ROW_CYC_LAST);
        last_read   = state == READ && cnt == ROW_CYC_LAST && row == ROW_LAST;
        start_frame = !ABORT && ((state == IDLE && START) || (last_read && CONTINUOUS));
        ramp_clear  = start_frame || (ABORT && state != IDLE);
        ramp_en     = state == CONVERT && cnt != CONV_LAST;
    end

    // frame sequencer; ABORT overrides every transition and suppresses FRAME_DONE
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            row        <= '0;
            exp_lat    <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= last_read && !ABORT;
            if (start_frame) exp_lat <= (EXPOSE_TIME == '0) ? EXP_BITS'(1) : EXPOSE_TIME;
            if (ABORT) begin
                state <= IDLE;
                cnt   <= '0;
                row   <= '0;
            end else begin
                cnt <= (state == IDLE || phase_last) ? '0 : cnt + CNT_W'(1);
                row <= (state == READ && phase_last) ? (last_read ? '0 : row + ROW_W'(1)) : row;
                case (state)
                    IDLE:    if (START) state <= ERASE;
                    ERASE:   if (phase_last) state <= EXPOSE;
                    EXPOSE:  if (phase_last) state <= CONVERT;
                    CONVERT: if (phase_last) state <= READ;
                    READ:    if (last_read) state <= CONTINUOUS ? ERASE : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sensor_gray_ramp #(.PIXEL_BITS(PIXEL_BITS)) u_ramp (
        .CLK    (CLK),
        .RESET  (RESET),
        .CLEAR  (ramp_clear),
        .ENABLE (ramp_en),
        .OUT    (DIGITAL_RAMP)
    );

    assign BUSY           = state != IDLE;
    assign PIXEL_ERASE    = state == ERASE;
    assign PIXEL_EXPOSE   = state == EXPOSE;
    assign ANALOG_RAMP_EN = state == CONVERT;
    assign ROW_SELECT     = (state == READ) ? ROWS'(1) << row : '0;
    assign NEW_ROW        = state == READ && cnt == '0;

`ifdef SENSOR_FRAME_COUNT_EN
    // counts completed frames only; aborted or reset frames never raise FRAME_DONE
    always_ff @(posedge CLK or posedge RESET)
        if (RESET) FRAME_COUNT <= '0;
        else if (FRAME_DONE) FRAME_COUNT <= FRAME_COUNT + FRAME_COUNT_BITS'(1);
`endif

endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// tb_sensor_frame_ctrl: directed self-checking bench for sensor_frame_ctrl (ROWS=4, PIXEL_BITS=4, ERASE=3, ROW_READ=2)
module tb_sensor_frame_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        CONTINUOUS = 1'b0;
    logic        ABORT = 1'b0;
    logic [9:0]  EXPOSE_TIME = '0;
    logic        BUSY, PIXEL_ERASE, PIXEL_EXPOSE, ANALOG_RAMP_EN, NEW_ROW, FRAME_DONE;
    logic [3:0]  DIGITAL_RAMP;
    logic [3:0]  ROW_SELECT;
`ifdef SENSOR_FRAME_COUNT_EN
    logic [15:0] FRAME_COUNT;
`endif

    int checks = 0;
    int errors = 0;

    int c_erase, c_exp, c_conv, c_read, c_busy, c_nr, c_fd, fd_idx, fd_er, idx, nconv, hold_bad;
    logic [3:0] rows [8];
    logic [3:0] ramp [32];
    logic [3:0] gray_ref [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    sensor_frame_ctrl #(
        .ROWS(4), .PIXEL_BITS(4), .ERASE_CYCLES(3), .ROW_READ_CYCLES(2), .EXP_BITS(10)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .START          (START),
        .CONTINUOUS     (CONTINUOUS),
        .ABORT          (ABORT),
        .EXPOSE_TIME    (EXPOSE_TIME),
        .BUSY           (BUSY),
        .PIXEL_ERASE    (PIXEL_ERASE),
        .PIXEL_EXPOSE   (PIXEL_EXPOSE),
        .ANALOG_RAMP_EN (ANALOG_RAMP_EN),
        .DIGITAL_RAMP   (DIGITAL_RAMP),
        .ROW_SELECT     (ROW_SELECT),
        .NEW_ROW        (NEW_ROW),
`ifdef SENSOR_FRAME_COUNT_EN
        .FRAME_COUNT    (FRAME_COUNT),
`endif
        .FRAME_DONE     (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [13:0] outs();
        return {BUSY, PIXEL_ERASE, PIXEL_EXPOSE, ANALOG_RAMP_EN, DIGITAL_RAMP, ROW_SELECT, NEW_ROW, FRAME_DONE};
    endfunction

    task automatic clr();
        c_erase = 0; c_exp = 0; c_conv = 0; c_read = 0; c_busy = 0; c_nr = 0;
        c_fd = 0; fd_idx = -1; fd_er = 0; idx = 0; nconv = 0; hold_bad = 0;
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            if (PIXEL_ERASE) c_erase++;
            if (PIXEL_EXPOSE) c_exp++;
            if (BUSY) c_busy++;
            if (ANALOG_RAMP_EN) begin
                if (nconv < 32) ramp[nconv] = DIGITAL_RAMP;
                nconv++;
                c_conv++;
            end
            if (ROW_SELECT != '0) begin
                c_read++;
                if (DIGITAL_RAMP !== 4'h8) hold_bad++;
            end
            if (NEW_ROW) begin
                if (c_nr < 8) rows[c_nr] = ROW_SELECT;
                c_nr++;
            end
            if (FRAME_DONE) begin
                if (fd_idx < 0) fd_idx = idx;
                c_fd++;
                if (PIXEL_ERASE) fd_er++;
            end
            idx++;
            tick();
        end
    endtask

    task automatic start_frame(input logic [9:0] e);
        EXPOSE_TIME = e;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("reset_outs", 32'(outs()), 0);
`ifdef SENSOR_FRAME_COUNT_EN
        chk("reset_count", 32'(FRAME_COUNT), 0);
`endif
        RESET = 1'b0;
        tick();
        chk("idle_outs", 32'(outs()), 0);

        // single frame: phase lengths, row walk, ramp sequence
        start_frame(10'd5);
        clr();
        observe(40);
        chk("t1_erase", c_erase, 3);
        chk("t1_expose", c_exp, 5);
        chk("t1_convert", c_conv, 16);
        chk("t1_read", c_read, 8);
        chk("t1_busy", c_busy, 32);
        chk("t1_new_row", c_nr, 4);
        chk("t1_frame_done", c_fd, 1);
        chk("t1_done_idx", fd_idx, 32);
        chk("t1_row0", 32'(rows[0]), 4'b0001);
        chk("t1_row1", 32'(rows[1]), 4'b0010);
        chk("t1_row2", 32'(rows[2]), 4'b0100);
        chk("t1_row3", 32'(rows[3]), 4'b1000);
        chk("t2_ramp_hold", hold_bad, 0);
        for (int k = 0; k < 16; k++) chk($sformatf("t2_ramp%0d", k), 32'(ramp[k]), 32'(gray_ref[k]));
        for (int k = 1; k < 16; k++) chk($sformatf("t2_step%0d", k), $countones(ramp[k] ^ ramp[k-1]), 1);

        // continuous mode with exposure reprogrammed during frame 1
        CONTINUOUS = 1'b1;
        start_frame(10'd5);
        EXPOSE_TIME = 10'd2;
        clr();
        observe(40);
        chk("t3_busy_w1", c_busy, 40);
        chk("t3_done_idx", fd_idx, 32);
        chk("t3_done_erase", fd_er, 1);
        chk("t3_expose_w1", c_exp, 7);
        chk("t3_erase_w1", c_erase, 6);
        CONTINUOUS = 1'b0;
        clr();
        observe(30);
        chk("t3_busy_w2", c_busy, 21);
        chk("t3_done_w2", c_fd, 1);
        chk("t3_done_idx_w2", fd_idx, 21);

        // abort on the third convert cycle
        start_frame(10'd5);
        repeat (10) tick();
        chk("t4_pre_ramp_en", 32'(ANALOG_RAMP_EN), 1);
        chk("t4_pre_ramp", 32'(DIGITAL_RAMP), 3);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("t4_abort_outs", 32'(outs()), 0);
        clr();
        observe(2);
        chk("t4_no_done", c_fd, 0);
        chk("t4_idle", c_busy, 0);
        start_frame(10'd5);
        clr();
        observe(40);
        chk("t4_restart_busy", c_busy, 32);
        chk("t4_restart_done", fd_idx, 32);
        ABORT = 1'b1;
        START = 1'b1;
        tick();
        ABORT = 1'b0;
        START = 1'b0;
        chk("t4_abort_start", 32'(BUSY), 0);

        // zero exposure and START while busy
        start_frame(10'd0);
        clr();
        observe(5);
        START = 1'b1;
        observe(1);
        START = 1'b0;
        observe(34);
        chk("t5_expose", c_exp, 1);
        chk("t5_busy", c_busy, 28);
        chk("t5_done_idx", fd_idx, 28);
        chk("t5_done_cnt", c_fd, 1);
`ifdef SENSOR_FRAME_COUNT_EN
        chk("t5_count", 32'(FRAME_COUNT), 5);
`endif

        // asynchronous reset mid-read
        start_frame(10'd5);
        repeat (26) tick();
        chk("t6_pre_row", 32'(ROW_SELECT), 4'b0010);
        RESET = 1'b1;
        #1;
        chk("t6_reset_outs", 32'(outs()), 0);
`ifdef SENSOR_FRAME_COUNT_EN
        chk("t6_reset_count", 32'(FRAME_COUNT), 0);
`endif
        tick();
        RESET = 1'b0;
        clr();
        observe(10);
        chk("t6_no_done", c_fd, 0);
        chk("t6_idle", c_busy, 0);
        start_frame(10'd5);
        clr();
        observe(40);
        chk("t6_frame_busy", c_busy, 32);
        chk("t6_frame_done", c_fd, 1);
`ifdef SENSOR_FRAME_COUNT_EN
        chk("t6_count", 32'(FRAME_COUNT), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
